lsu_mem: RTL
============

LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width.
REQ-002 Parameter TIMEOUT, default 255: maximum BUSY cycles waiting for mem_ack.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port memWE, input, 1: memory-stage store request.
REQ-006 Port memRE, input, 1: memory-stage load request (memtoreg of M).
REQ-007 Port addr, input, ADDR_W: byte address (M-stage aluout).
REQ-008 Port writedata, input, 32: store data, right-aligned.
REQ-009 Port memcontrol, input, 3: funct3 size/sign code.
REQ-010 Port readdata, output, 32: extended load result.
REQ-011 Port stall, output, 1: freezes the pipeline while an access is in flight.
REQ-012 Port fault, output, 1: one-cycle pulse on misaligned, illegal or timed-out access.
REQ-013 Port mem_req, output, 1: backing-memory request.
REQ-014 Port mem_we, output, 1: backing-memory write.
REQ-015 Port mem_addr, output, ADDR_W-2: word address.
REQ-016 Port mem_be, output, 4: byte enables.
REQ-017 Port mem_wdata, output, 32: lane-replicated store data.
REQ-018 Port mem_ack, input, 1: backing memory completes the access this cycle.
REQ-019 Port mem_rdata, input, 32: read word, valid when mem_ack=1.

Function
REQ-020 The block SHALL implement the FSM states IDLE, BUSY, DONE and ERR.
REQ-021 IDLE with exactly one of memRE/memWE set, a legal code and an aligned address SHALL: latch mem_addr, mem_be, mem_wdata and mem_we; move to BUSY; drive stall=1 that cycle.
REQ-022 BUSY SHALL hold mem_req=1 with the latched fields unchanged, keep stall=1, and move to DONE on mem_ack=1.
REQ-023 DONE SHALL last exactly one cycle with stall=0, then return to IDLE.
REQ-024 An access with ack in its first BUSY cycle SHALL therefore take 3 cycles (IDLE, BUSY, DONE).
REQ-025 Legal load codes: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store codes: 000 SB, 001 SH, 010 SW. Every other code, and memRE=memWE=1, SHALL be illegal.
REQ-026 Misalignment: halfword accesses with addr[0]=1, and word accesses with addr[1:0]!=0.
REQ-027 Misaligned or illegal requests in IDLE SHALL go to ERR without asserting mem_req.
REQ-028 BUSY SHALL count cycles and go to ERR after TIMEOUT cycles without mem_ack; the counter SHALL clear on entry to BUSY.
REQ-029 ERR SHALL last one cycle with stall=0, fault=1 and readdata=0, then return to IDLE.
REQ-030 Store lanes: SB mem_be=0001<<addr[1:0] with the byte replicated into all four lanes; SH mem_be=0011<<addr[1:0] with the halfword replicated; SW mem_be=1111.
REQ-031 Loads: on mem_ack, readdata SHALL register the selected byte/halfword/word from mem_rdata at addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-032 readdata SHALL hold its value until the next load completes or an ERR occurs.
REQ-033 Stores SHALL leave readdata unchanged.
REQ-034 stall SHALL be 0 in IDLE when no request is present.
REQ-035 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-036 When reset=0 at a clock edge: state=IDLE, timeout counter=0, readdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, fault=0.
REQ-037 Reset during BUSY SHALL drop mem_req on the next edge and abandon the access; a late mem_ack SHALL have no effect.

Structure
REQ-038 Package lsu_pkg SHALL hold the funct3 load/store constants and the FSM state type.
REQ-039 Sub-module lsu_align SHALL be purely combinational and provide byte-enable/lane replication for stores and lane select/extension for loads.

Verification
REQ-040 LB, addr=0x103, mem_rdata=0x80AABBCC, ack in first BUSY cycle -> readdata=0xFFFFFF80 in DONE (cycle 3), stall=1,1,0.
REQ-041 SH, addr=0x202, writedata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x80, mem_we=1.
REQ-042 LW, addr=0x101 -> mem_req never asserted, fault pulse, readdata=0, stall=1 for one cycle.
REQ-043 LHU, addr=0x0, TIMEOUT=4, mem_ack held 0 -> ERR after 4 BUSY cycles, fault=1, then IDLE.
REQ-044 reset=0 in the second BUSY cycle, then mem_ack=1 after reset releases -> state IDLE, mem_req=0, readdata unchanged at 0.
REQ-045 Back-to-back LW then SW with ack in first BUSY cycle -> each access takes 3 cycles; DONE, IDLE, BUSY sequence correct; first load data retained through the store.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared funct3 size/sign codes, FSM state type and request legality helpers
// for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsuState_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only exist for loads.
  function automatic logic legalCode(input logic [2:0] f3, input logic isLoad);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = isLoad;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables/replication and load lane
// select with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeData,
  input  logic [31:0] wordIn,
  output logic [3:0]  byteEn,
  output logic [31:0] laneData,
  output logic [31:0] loadData
);

  logic [31:0] shifted;

  always_comb begin
    byteEn   = 4'b1111;
    laneData = storeData;
    case (funct3[1:0])
      2'b00: begin
        byteEn   = 4'b0001 << addrLo;
        laneData = {4{storeData[7:0]}};
      end
      2'b01: begin
        byteEn   = 4'b0011 << addrLo;
        laneData = {2{storeData[15:0]}};
      end
      default: begin
        byteEn   = 4'b1111;
        laneData = storeData;
      end
    endcase
  end

  always_comb begin
    shifted  = wordIn >> {addrLo, 3'b000};
    loadData = shifted;
    case (funct3)
      F3_B:    loadData = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    loadData = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   loadData = {24'd0, shifted[7:0]};
      F3_HU:   loadData = {16'd0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Memory-stage load/store unit: one outstanding access to a word-addressed
// backing memory, with alignment/legality checking and an ack timeout.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memWE,
  input  logic              memRE,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       writedata,
  input  logic [2:0]        memcontrol,
  output logic [31:0]       readdata,
  output logic              stall,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output lsuState_e         stateDbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsuState_e        state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic [2:0]       f3Q;
  logic [1:0]       loQ;
  logic             reqAny, reqOk;
  logic [2:0]       alignF3;
  logic [1:0]       alignLo;
  logic [3:0]       alignBe;
  logic [31:0]      alignWdata, alignLoad;

  assign reqAny = memRE | memWE;
  assign reqOk  = (memRE ^ memWE) && legalCode(memcontrol, memRE)
                  && !misaligned(memcontrol, addr[1:0]);

  // Store lanes are computed from live inputs in IDLE; load extraction
  // uses the fields latched when the access was accepted.
  assign alignF3 = (state == IDLE) ? memcontrol : f3Q;
  assign alignLo = (state == IDLE) ? addr[1:0] : loQ;

  lsu_align uAlign (
    .funct3    (alignF3),
    .addrLo    (alignLo),
    .storeData (writedata),
    .wordIn    (mem_rdata),
    .byteEn    (alignBe),
    .laneData  (alignWdata),
    .loadData  (alignLoad)
  );

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (reqAny) begin
          stall     = 1'b1;
          nextState = reqOk ? BUSY : ERR;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack)                                nextState = DONE;
        else if (waitCnt == CNT_W'(TIMEOUT - 1))    nextState = ERR;
      end
      DONE:    nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign fault    = (state == ERR);
  assign stateDbg = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      waitCnt   <= '0;
      readdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f3Q       <= '0;
      loQ       <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && nextState == BUSY) begin
        mem_req   <= 1'b1;
        mem_we    <= memWE;
        mem_be    <= alignBe;
        mem_addr  <= addr[ADDR_W-1:2];
        mem_wdata <= alignWdata;
        f3Q       <= memcontrol;
        loQ       <= addr[1:0];
        waitCnt   <= '0;
      end
      if (state == BUSY) begin
        waitCnt <= waitCnt + 1'b1;
        if (nextState != BUSY) mem_req <= 1'b0;
        if (mem_ack && !mem_we) readdata <= alignLoad;
      end
      if (nextState == ERR) readdata <= '0;
    end
  end

endmodule
